btn_event_queue: RTL



---
 rtl/btn_event_queue.sv | 94 +++++++++
 1 files changed

// File: rtl/btn_event_queue.sv
// Turns one-shot button pulses into button-index events held in a small FIFO.
// The interrupt stays high until the CPU has popped every event.
module btn_event_queue #(
  parameter int N_BTN = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_BTN-1:0]         db_btn_i,
  input  logic                     rd_i,
  output logic [7:0]               evt_data_o,
  output logic [$clog2(DEPTH):0]   evt_count_o,
  output logic                     intr_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [N_BTN-1:0] prevBtn_q, pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [3:0]       mem [DEPTH];

  logic [N_BTN-1:0] btnEdge, cand, selMask;
  logic [3:0]       selIdx;
  logic             selFound, canAccept, push, pop, evtValid;

  // Lowest pending or newly rising index wins; the rest wait in pend.
  always_comb begin
    btnEdge  = db_btn_i & ~prevBtn_q;
    cand     = pend_q | btnEdge;
    selMask  = '0;
    selIdx   = '0;
    selFound = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (cand[i] && !selFound) begin
        selMask[i] = 1'b1;
        selIdx     = 4'(i);
        selFound   = 1'b1;
      end
    end
    pop       = rd_i && (count_q != '0);
    canAccept = (count_q < FULL) || pop;
    push      = canAccept && selFound;
    pend_d    = push ? (cand & ~selMask) : cand;
    ovf_d     = pop ? 1'b0 : ovf_q;
    if (|(btnEdge & pend_q)) begin
      ovf_d = 1'b1;
    end
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prevBtn_q <= '1;
      pend_q    <= '0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
    end else begin
      prevBtn_q <= db_btn_i;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
      if (push) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
    end
  end

  // Storage is never reset; count_q decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wrPtr_q] <= selIdx;
    end
  end

  assign evtValid    = (count_q != '0);
  assign evt_data_o  = {evtValid, ovf_q, 2'b00, evtValid ? mem[rdPtr_q] : 4'h0};
  assign evt_count_o = count_q;
  assign intr_o      = evtValid;

endmodule
